fb_scanout: RTL
===============

// Module: fb_scanout
// PURPOSE
//  Read side of the 64x64x8 framebuffer RAM that voxel_engine writes. Fetches one framebuffer row
//  per SCALE lines into a ping-pong line buffer during hblank, then streams scaled pixels to video
//  out in sync with hpos/vpos. Shares the RAM port with the writer through a rd_req/rd_gnt handshake.
// PARAMETERS
//  FB_W_LOG2   6    log2 framebuffer width; row length = 64 bytes
//  FB_H_LOG2   6    log2 framebuffer height; rd_addr = {row[5:0], col[5:0]} (12 bits)
//  SCALE_LOG2  2    each fb pixel covers 4x4 screen pixels
//  H_ACTIVE    256  active pixels per line; hpos == H_ACTIVE is the first hblank cycle
//  V_ACTIVE    240  active lines per frame
//  V_TOTAL     262  total lines per frame; vpos counts 0..V_TOTAL-1
// PORTS
//  clk         in   1   pixel clock
//  reset_n     in   1   asynchronous, active-low reset
//  hpos        in   9   current horizontal position from the sync generator
//  vpos        in   9   current vertical position from the sync generator
//  display_on  in   1   sync generator active-video flag
//  rd_req      out  1   RAM read request; held high until the fetch completes
//  rd_addr     out  12  RAM read address; valid while rd_req = 1
//  rd_gnt      in   1   arbiter grant; rd_addr is accepted on a cycle with rd_req & rd_gnt
//  rd_data     in   8   RAM data; valid exactly 1 cycle after an accepted request
//  pix         out  8   pixel colour index; 0 whenever pix_valid = 0
//  pix_valid   out  1   pix carries active video
//  underrun    out  1   sticky flag: a fetch missed its deadline; cleared only by reset
// BEHAVIOUR
//  Reset (async, reset_n=0): rd_req=0, rd_addr=0, pix=0, pix_valid=0, underrun=0, FSM=IDLE,
//   buf_ok=0. Buffer RAM is not cleared. rd_req drops in the same cycle reset asserts, even mid-fetch.
//  nv = (vpos == V_TOTAL-1) ? 0 : vpos+1.
//  Fetch trigger: hpos == H_ACTIVE && nv < V_ACTIVE && nv[1:0] == 0. Fetch row = nv >> SCALE_LOG2.
//  FSM:
//   IDLE -> REQ on trigger; col=0.
//   REQ: rd_req=1, rd_addr={row,col}. On rd_gnt, col++ and the beat is recorded; rd_data of the
//    previous accepted beat is written to back[col_d]. Accepting col 63 -> LAST.
//   LAST: 1 cycle; writes the final beat, rd_req=0 -> DONE.
//   DONE: at hpos == 0 (start of line nv), swap front/back, set buf_ok=1 -> IDLE.
//   Deadline: at hpos == 0 in REQ or LAST, abort (rd_req=0), set underrun=1, do not swap -> IDLE.
//    The old front buffer keeps displaying.
//  rd_gnt while rd_req=0 is ignored. Grants may be non-consecutive; a gap stalls col.
//  Trigger while not IDLE (impossible with legal timing) is ignored.
//  Scanout: 2-cycle pipeline. S1 registers idx = hpos[7:2] and v_ok = display_on & hpos < H_ACTIVE
//   & vpos < V_ACTIVE. S2 outputs pix = (v_ok & buf_ok) ? front[idx] : 0, and pix_valid = v_ok.
//   pix at cycle t+2 corresponds to hpos at cycle t; downstream delays hsync/vsync by 2.
//  The front buffer is only read and the back buffer only written; a swap at hpos == 0 is safe
//   because the pipeline is empty at line start.
// STRUCTURE
//  fb_pkg:
//   - FB_W_LOG2, FB_H_LOG2, SCALE_LOG2, address width 12.
//   - fetch_state_t {IDLE, REQ, LAST, DONE}.
//  fb_line_buffer submodule:
//   - 2 x 64 x 8 storage, 1 synchronous write port and 1 synchronous read port.
//   - 'sel' input picks the front bank; write goes to the back bank.
//  fb_scanout holds the fetch FSM, deadline/underrun logic, and the scanout pipeline.
// TESTING
//  1 rd_gnt tied high, RAM[{r,c}] = r^c, full frame
//     -> line 4 shows pix = 1^(hpos>>2), each repeated 4 cycles.
//     -> 64 accepted reads per fetch; underrun stays 0.
//  2 rd_gnt high 1 cycle in 2 -> fetch takes 128+1 cycles; pixel data is identical to test 1.
//  3 rd_gnt held low from hblank of line 3
//     -> underrun=1 at line 4 hpos 0; lines 4-7 repeat row 0 data.
//  4 reset_n=0 mid-fetch at col 20 -> rd_req=0 in the same cycle, all outputs 0.
//     After release, pix=0 until the first completed swap (buf_ok=0).
//  5 vpos >= 240 or display_on=0 -> pix_valid=0, pix=0.
//     vpos 261 hblank -> row 0 fetched; line 0 shows row 0.
//  6 Pixel alignment: hpos 0..3 of line 0 -> pix = RAM[0] on cycles 2..5; RAM[1] at cycle 6.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// ==== fb_pkg : framebuffer geometry and fetch-state encoding (rev 1.0) ====
package fb_pkg;
  localparam int FB_W_LOG2  = 6;
  localparam int FB_H_LOG2  = 6;
  localparam int SCALE_LOG2 = 2;
  localparam int ADDR_W     = FB_W_LOG2 + FB_H_LOG2;
  localparam int FB_W       = 1 << FB_W_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } fetch_state_t;
endpackage
`default_nettype wire

// File: rtl/fb_line_buffer.sv
`default_nettype none
// ==== fb_line_buffer : ping-pong 2x64x8 line store, back bank written, front bank read (rev 1.0) ====
module fb_line_buffer
  import fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sel,
  input  logic                 wr_en,
  input  logic [FB_W_LOG2-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 rd_en,
  input  logic [FB_W_LOG2-1:0] rd_addr,
  output logic [7:0]           rd_data
);
  logic [7:0] mem [0:2*FB_W-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{~sel, wr_addr}] <= wr_data;
  end

  // Read port doubles as the blanking mux: disabled reads return colour 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= rd_en ? mem[{sel, rd_addr}] : 8'd0;
  end
endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ==== fb_scanout : framebuffer row fetch into line buffer + scaled pixel scanout (rev 1.0) ====
module fb_scanout
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 240,
  parameter int V_TOTAL  = 262
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [8:0]        hpos,
  input  logic [8:0]        vpos,
  input  logic              display_on,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic [7:0]        rd_data,
  output logic [7:0]        pix,
  output logic              pix_valid,
  output logic              underrun
);
  fetch_state_t         state;
  logic [8:0]           nv;
  logic                 trigger;
  logic                 line_start;
  logic                 accept;
  logic                 beat_v;
  logic [FB_W_LOG2-1:0] beat_col;
  logic                 sel;
  logic                 buf_ok;
  logic [FB_W_LOG2-1:0] idx_s1;
  logic                 v_ok_s1;

  assign nv         = (vpos == 9'(V_TOTAL - 1)) ? 9'd0 : vpos + 9'd1;
  assign trigger    = (hpos == 9'(H_ACTIVE)) && (nv < 9'(V_ACTIVE)) &&
                      (nv[SCALE_LOG2-1:0] == '0);
  assign line_start = (hpos == 9'd0);
  assign accept     = rd_req && rd_gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      underrun <= 1'b0;
      sel      <= 1'b0;
      buf_ok   <= 1'b0;
      beat_v   <= 1'b0;
      beat_col <= '0;
    end else begin
      // RAM data lands one cycle after acceptance; remember which column it belongs to.
      beat_v <= accept;
      if (accept) beat_col <= rd_addr[FB_W_LOG2-1:0];
      case (state)
        IDLE: begin
          if (trigger) begin
            state   <= REQ;
            rd_req  <= 1'b1;
            rd_addr <= {nv[SCALE_LOG2 +: FB_H_LOG2], {FB_W_LOG2{1'b0}}};
          end
        end
        REQ: begin
          if (line_start) begin
            state    <= IDLE;
            rd_req   <= 1'b0;
            underrun <= 1'b1;
          end else if (accept) begin
            rd_addr[FB_W_LOG2-1:0] <= rd_addr[FB_W_LOG2-1:0] + FB_W_LOG2'(1);
            if (&rd_addr[FB_W_LOG2-1:0]) begin
              state  <= LAST;
              rd_req <= 1'b0;
            end
          end
        end
        LAST: begin
          if (line_start) begin
            state    <= IDLE;
            underrun <= 1'b1;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (line_start) begin
            state  <= IDLE;
            sel    <= ~sel;
            buf_ok <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_s1    <= '0;
      v_ok_s1   <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      idx_s1    <= hpos[SCALE_LOG2 +: FB_W_LOG2];
      v_ok_s1   <= display_on && (hpos < 9'(H_ACTIVE)) && (vpos < 9'(V_ACTIVE));
      pix_valid <= v_ok_s1;
    end
  end

  fb_line_buffer u_line_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .sel     (sel),
    .wr_en   (beat_v),
    .wr_addr (beat_col),
    .wr_data (rd_data),
    .rd_en   (v_ok_s1 && buf_ok),
    .rd_addr (idx_s1),
    .rd_data (pix)
  );
endmodule
`default_nettype wire
